// File: rtl/otter_iobus_timer_if.sv
// OTTER IOBUS connection between the CPU (master) and the interval timer
// (slave): address/data/strobes toward the timer, read data, hit flag and
// the interrupt line back toward the CPU.
interface otter_iobus_timer_if;
    logic [31:0] IOBUS_ADDR;
    logic [31:0] IOBUS_OUT;
    logic        IOBUS_WR;
    logic        IOBUS_RD;
    logic [31:0] IO_RDATA;
    logic        IO_HIT;
    logic        INTR;
    logic        INTR_ACK;

    modport master (
        output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, IOBUS_RD, INTR_ACK,
        input  IO_RDATA, IO_HIT, INTR
    );

    modport slave (
        input  IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, IOBUS_RD, INTR_ACK,
        output IO_RDATA, IO_HIT, INTR
    );
endinterface

// File: rtl/otter_iobus_timer.sv
// Memory-mapped interval timer on the OTTER IOBUS.
// Registers (word offsets from BASE_ADDR):
//   0x00 CTRL  [0] EN, [1] RELOAD, [2] IE
//   0x04 PRESC prescaler reload value
//   0x08 CMP   compare value
//   0x0C COUNT current count (read/write)
//   0x10 STATUS [0] PEND (W1C), [1] OVR (W1C, only with OTTER_TIMER_OVR_EN)
// Optional feature macro: OTTER_TIMER_OVR_EN builds the overrun flag.
module otter_iobus_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
    parameter int          PRESC_W   = 16
) (
    input  logic CLK,
    input  logic RESET,
    otter_iobus_timer_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t state, state_nx;

    logic               en, reload, ie, pend, ovr;
    logic [PRESC_W-1:0] presc, psc_cnt;
    logic [31:0]        cmp, count;
    logic [31:0]        rd_mux;

    logic       hit;
    logic [2:0] off;
    logic       wr_ctrl, wr_presc, wr_cmp, wr_count, wr_status;
    logic       tick, match;

    // Byte-lane bits are ignored: every access is a full word.
    logic unused_addr;
    assign unused_addr = ^bus.IOBUS_ADDR[1:0];

    assign hit       = (bus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
    assign off       = bus.IOBUS_ADDR[4:2];
    assign wr_ctrl   = bus.IOBUS_WR && hit && (off == 3'd0);
    assign wr_presc  = bus.IOBUS_WR && hit && (off == 3'd1);
    assign wr_cmp    = bus.IOBUS_WR && hit && (off == 3'd2);
    assign wr_count  = bus.IOBUS_WR && hit && (off == 3'd3);
    assign wr_status = bus.IOBUS_WR && hit && (off == 3'd4);

    // Tick when the prescaler reaches PRESC; match when COUNT sits on CMP at a tick.
    assign tick  = (state == RUN) && (psc_cnt == presc);
    assign match = tick && (count == cmp);

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_nx;
    end

    // Next state: a CTRL write decides outright; otherwise a one-shot match stops the timer.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (wr_ctrl && bus.IOBUS_OUT[0]) state_nx = RUN;
            end
            RUN: begin
                if (wr_ctrl)                state_nx = bus.IOBUS_OUT[0] ? RUN : IDLE;
                else if (match && !reload)  state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // CTRL register; a one-shot match drops EN unless software rewrites CTRL that cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            en     <= 1'b0;
            reload <= 1'b0;
            ie     <= 1'b0;
        end else if (wr_ctrl) begin
            en     <= bus.IOBUS_OUT[0];
            reload <= bus.IOBUS_OUT[1];
            ie     <= bus.IOBUS_OUT[2];
        end else if (match && !reload) begin
            en     <= 1'b0;
        end
    end

    // PRESC and CMP registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            presc <= '0;
            cmp   <= '0;
        end else begin
            if (wr_presc) presc <= bus.IOBUS_OUT[PRESC_W-1:0];
            if (wr_cmp)   cmp   <= bus.IOBUS_OUT;
        end
    end

    // Prescaler counter: restarts on a PRESC write or when software stops the timer.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                                psc_cnt <= '0;
        else if (wr_presc)                        psc_cnt <= '0;
        else if (wr_ctrl && !bus.IOBUS_OUT[0])    psc_cnt <= '0;
        else if (state == RUN)                    psc_cnt <= tick ? '0 : psc_cnt + 1'b1;
    end

    // Main counter: a software write beats the tick update.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)         count <= '0;
        else if (wr_count) count <= bus.IOBUS_OUT;
        else if (tick)     count <= match ? 32'd0 : count + 32'd1;
    end

    // Pending flag: a match wins over W1C or acknowledge in the same cycle.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                                          pend <= 1'b0;
        else if (match)                                     pend <= 1'b1;
        else if ((wr_status && bus.IOBUS_OUT[0]) || bus.INTR_ACK) pend <= 1'b0;
    end

`ifdef OTTER_TIMER_OVR_EN
    // Overrun flag: a match arriving while PEND is still set; only W1C clears it.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                              ovr <= 1'b0;
        else if (match && pend)                 ovr <= 1'b1;
        else if (wr_status && bus.IOBUS_OUT[1]) ovr <= 1'b0;
    end
`else
    assign ovr = 1'b0;
`endif

    // Read data selection from the current register values.
    always_comb begin
        rd_mux = 32'd0;
        case (off)
            3'd0:    rd_mux = {29'd0, ie, reload, en};
            3'd1:    rd_mux = 32'(presc);
            3'd2:    rd_mux = cmp;
            3'd3:    rd_mux = count;
            3'd4:    rd_mux = {30'd0, ovr, pend};
            default: rd_mux = 32'd0;
        endcase
    end

    // Registered read port: one-cycle latency, data held between reads.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bus.IO_RDATA <= 32'd0;
            bus.IO_HIT   <= 1'b0;
        end else if (bus.IOBUS_RD && hit) begin
            bus.IO_RDATA <= rd_mux;
            bus.IO_HIT   <= 1'b1;
        end else begin
            bus.IO_HIT   <= 1'b0;
        end
    end

    // Interrupt straight from flops, no path from the bus inputs.
    assign bus.INTR = pend & ie;

endmodule
